// File: rtl/masked_serial_split.sv
`default_nettype none
// ============================================================================
// Module   : masked_serial_split
// Brief    : Splits one masked multi-share word into NUM_PARTS masked parts
//            over a valid/ready stream, keeping each share on its own path.
// Revision : 1.0 - initial release
// ============================================================================
module masked_serial_split #(
  parameter int NUM_SHARES = 2,
  parameter int PART_WIDTH = 8,
  parameter int NUM_PARTS  = 4,
  parameter int MSB_FIRST  = 0,
  parameter int IDX_WIDTH  = (NUM_PARTS > 1) ? $clog2(NUM_PARTS) : 1
) (
  input  logic                                            in_clock,
  input  logic                                            in_reset,
  input  logic [NUM_SHARES-1:0][NUM_PARTS*PART_WIDTH-1:0] in_a,
  input  logic                                            in_a_valid,
  output logic                                            out_a_ready,
  output logic [NUM_SHARES-1:0][PART_WIDTH-1:0]           out_b,
  output logic                                            out_b_valid,
  input  logic                                            in_b_ready,
  output logic [IDX_WIDTH-1:0]                            out_b_index,
  output logic                                            out_b_last
);

  localparam int WORD_WIDTH = NUM_PARTS * PART_WIDTH;
  localparam logic [IDX_WIDTH-1:0] c_last_idx = IDX_WIDTH'(NUM_PARTS - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t                                r_state;
  state_t                                w_state_nxt;
  logic [IDX_WIDTH-1:0]                  r_cnt;
  logic [IDX_WIDTH-1:0]                  w_cnt_nxt;
  logic [NUM_SHARES-1:0][WORD_WIDTH-1:0] r_sh;
  logic [NUM_SHARES-1:0][WORD_WIDTH-1:0] w_sh_nxt;
  logic [NUM_SHARES-1:0][WORD_WIDTH-1:0] w_sh_shift;
  logic                                  w_busy;
  logic                                  w_last;
  logic                                  w_accept;
  logic                                  w_emit;

  assign w_busy   = (r_state == ST_BUSY);
  assign w_last   = w_busy && (r_cnt == c_last_idx);
  assign w_emit   = w_busy && in_b_ready;
  assign w_accept = in_a_valid && out_a_ready;

  assign out_a_ready = !w_busy || (w_last && in_b_ready);
  assign out_b_valid = w_busy;
  assign out_b_last  = w_last;
  assign out_b_index = !w_busy ? '0 : ((MSB_FIRST != 0) ? (c_last_idx - r_cnt) : r_cnt);

  // Each share is shifted and tapped independently; no cross-share logic.
  genvar s;
  generate
    for (s = 0; s < NUM_SHARES; s++) begin : g_share
      if (NUM_PARTS == 1) begin : g_single
        assign w_sh_shift[s] = '0;
      end else if (MSB_FIRST != 0) begin : g_shift_msb
        assign w_sh_shift[s] = {r_sh[s][WORD_WIDTH-PART_WIDTH-1:0], {PART_WIDTH{1'b0}}};
      end else begin : g_shift_lsb
        assign w_sh_shift[s] = {{PART_WIDTH{1'b0}}, r_sh[s][WORD_WIDTH-1:PART_WIDTH]};
      end

      if (MSB_FIRST != 0) begin : g_tap_msb
        assign out_b[s] = r_sh[s][WORD_WIDTH-1 -: PART_WIDTH];
      end else begin : g_tap_lsb
        assign out_b[s] = r_sh[s][PART_WIDTH-1:0];
      end
    end
  endgenerate

  // Shifting on the last emit too clears the registers, so idle output is zero.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sh_nxt    = r_sh;
    if (w_accept) begin
      w_state_nxt = ST_BUSY;
      w_cnt_nxt   = '0;
      w_sh_nxt    = in_a;
    end else if (w_emit) begin
      w_sh_nxt = w_sh_shift;
      if (w_last) begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end else begin
        w_cnt_nxt = r_cnt + IDX_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_sh    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sh    <= w_sh_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_masked_serial_split.sv
`default_nettype none
// ============================================================================
// Module   : tb_masked_serial_split
// Brief    : Directed bench for masked_serial_split (LSB-first, MSB-first and
//            single-part instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_masked_serial_split;

  logic clk;
  logic rst;

  // LSB-first, 2 shares x 4 parts x 8 bits
  logic [1:0][31:0] a_in;
  logic             a_valid;
  logic             a_bready;
  logic             a_ready;
  logic [1:0][7:0]  a_b;
  logic             a_bvalid;
  logic [1:0]       a_idx;
  logic             a_last;

  // MSB-first instance
  logic [1:0][31:0] m_in;
  logic             m_valid;
  logic             m_bready;
  logic             m_ready;
  logic [1:0][7:0]  m_b;
  logic             m_bvalid;
  logic [1:0]       m_idx;
  logic             m_last;

  // Single part of 16 bits
  logic [1:0][15:0] o_in;
  logic             o_valid;
  logic             o_bready;
  logic             o_ready;
  logic [1:0][15:0] o_b;
  logic             o_bvalid;
  logic [0:0]       o_idx;
  logic             o_last;

  int vectors;
  int miscompares;

  logic [7:0] w1_s0 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] w1_s1 [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
  logic [7:0] w2_s0 [4] = '{8'h05, 8'h06, 8'h07, 8'h08};
  logic [7:0] w2_s1 [4] = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};

  masked_serial_split #(.NUM_SHARES(2), .PART_WIDTH(8), .NUM_PARTS(4), .MSB_FIRST(0)) u_lsb (
    .in_clock(clk), .in_reset(rst), .in_a(a_in), .in_a_valid(a_valid),
    .out_a_ready(a_ready), .out_b(a_b), .out_b_valid(a_bvalid),
    .in_b_ready(a_bready), .out_b_index(a_idx), .out_b_last(a_last)
  );

  masked_serial_split #(.NUM_SHARES(2), .PART_WIDTH(8), .NUM_PARTS(4), .MSB_FIRST(1)) u_msb (
    .in_clock(clk), .in_reset(rst), .in_a(m_in), .in_a_valid(m_valid),
    .out_a_ready(m_ready), .out_b(m_b), .out_b_valid(m_bvalid),
    .in_b_ready(m_bready), .out_b_index(m_idx), .out_b_last(m_last)
  );

  masked_serial_split #(.NUM_SHARES(2), .PART_WIDTH(16), .NUM_PARTS(1), .MSB_FIRST(0)) u_one (
    .in_clock(clk), .in_reset(rst), .in_a(o_in), .in_a_valid(o_valid),
    .out_a_ready(o_ready), .out_b(o_b), .out_b_valid(o_bvalid),
    .in_b_ready(o_bready), .out_b_index(o_idx), .out_b_last(o_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1;
    a_in = '0; a_valid = 1'b0; a_bready = 1'b0;
    m_in = '0; m_valid = 1'b0; m_bready = 1'b0;
    o_in = '0; o_valid = 1'b0; o_bready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_valid", 64'(a_bvalid), 64'd0);
    chk("rst_b", 64'(a_b), 64'd0);
    chk("rst_idx", 64'(a_idx), 64'd0);
    chk("rst_last", 64'(a_last), 64'd0);
    chk("rst_ready", 64'(a_ready), 64'd1);
    chk("rst_msb_idx", 64'(m_idx), 64'd0);
    chk("rst_one_ready", 64'(o_ready), 64'd1);

    // Basic LSB-first
    a_in = {32'hDDCCBBAA, 32'h44332211};
    a_valid = 1'b1; a_bready = 1'b1;
    tick();
    a_valid = 1'b0;
    for (int p = 0; p < 4; p++) begin
      chk("lsb_valid", 64'(a_bvalid), 64'd1);
      chk("lsb_b", 64'(a_b), 64'({w1_s1[p], w1_s0[p]}));
      chk("lsb_idx", 64'(a_idx), 64'(p));
      chk("lsb_last", 64'(a_last), 64'(p == 3));
      tick();
    end
    chk("lsb_end_valid", 64'(a_bvalid), 64'd0);
    chk("lsb_end_b", 64'(a_b), 64'd0);

    // MSB-first, same word
    m_in = {32'hDDCCBBAA, 32'h44332211};
    m_valid = 1'b1; m_bready = 1'b1;
    tick();
    m_valid = 1'b0;
    for (int p = 0; p < 4; p++) begin
      chk("msb_b", 64'(m_b), 64'({w1_s1[3-p], w1_s0[3-p]}));
      chk("msb_idx", 64'(m_idx), 64'(3 - p));
      chk("msb_last", 64'(m_last), 64'(p == 3));
      tick();
    end
    chk("msb_end_valid", 64'(m_bvalid), 64'd0);
    chk("msb_end_b", 64'(m_b), 64'd0);

    // Backpressure during part 1
    a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    chk("bp_p0", 64'(a_b), 64'({8'hAA, 8'h11}));
    tick();
    a_bready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("bp_hold_b", 64'(a_b), 64'({8'hBB, 8'h22}));
      chk("bp_hold_idx", 64'(a_idx), 64'd1);
      chk("bp_hold_last", 64'(a_last), 64'd0);
      chk("bp_hold_ready", 64'(a_ready), 64'd0);
      tick();
    end
    a_bready = 1'b1;
    for (int p = 1; p < 4; p++) begin
      chk("bp_b", 64'(a_b), 64'({w1_s1[p], w1_s0[p]}));
      chk("bp_idx", 64'(a_idx), 64'(p));
      tick();
    end
    chk("bp_end_valid", 64'(a_bvalid), 64'd0);

    // Back-to-back words
    a_valid = 1'b1;
    tick();
    a_in = {32'h0D0C0B0A, 32'h08070605};
    for (int p = 0; p < 4; p++) begin
      chk("b2b_w1_b", 64'(a_b), 64'({w1_s1[p], w1_s0[p]}));
      chk("b2b_ready", 64'(a_ready), 64'(p == 3));
      tick();
    end
    a_valid = 1'b0;
    for (int p = 0; p < 4; p++) begin
      chk("b2b_w2_valid", 64'(a_bvalid), 64'd1);
      chk("b2b_w2_b", 64'(a_b), 64'({w2_s1[p], w2_s0[p]}));
      chk("b2b_w2_idx", 64'(a_idx), 64'(p));
      chk("b2b_w2_last", 64'(a_last), 64'(p == 3));
      tick();
    end
    chk("b2b_end_valid", 64'(a_bvalid), 64'd0);

    // Reset mid-word after part 1 has been emitted
    a_in = {32'hDDCCBBAA, 32'h44332211};
    a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    tick();
    tick();
    chk("mid_pre_idx", 64'(a_idx), 64'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_valid", 64'(a_bvalid), 64'd0);
    chk("mid_b", 64'(a_b), 64'd0);
    chk("mid_ready", 64'(a_ready), 64'd1);
    a_in = {32'h0D0C0B0A, 32'h08070605};
    a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    for (int p = 0; p < 4; p++) begin
      chk("mid_new_b", 64'(a_b), 64'({w2_s1[p], w2_s0[p]}));
      chk("mid_new_idx", 64'(a_idx), 64'(p));
      tick();
    end
    chk("mid_end_valid", 64'(a_bvalid), 64'd0);

    // Single-part configuration with back-to-back accept
    o_in = {16'h1234, 16'hBEEF};
    o_valid = 1'b1; o_bready = 1'b1;
    chk("one_ready0", 64'(o_ready), 64'd1);
    tick();
    o_in = {16'h5678, 16'hCAFE};
    chk("one_b", 64'(o_b), 64'({16'h1234, 16'hBEEF}));
    chk("one_idx", 64'(o_idx), 64'd0);
    chk("one_last", 64'(o_last), 64'd1);
    chk("one_valid", 64'(o_bvalid), 64'd1);
    chk("one_ready", 64'(o_ready), 64'd1);
    tick();
    o_valid = 1'b0;
    chk("one_b2", 64'(o_b), 64'({16'h5678, 16'hCAFE}));
    chk("one_last2", 64'(o_last), 64'd1);
    tick();
    chk("one_end_valid", 64'(o_bvalid), 64'd0);
    chk("one_end_b", 64'(o_b), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/masked_serial_split.md
# masked_serial_split

Sequential, parametrised successor to the combinational masked bit-vector splitter. It accepts one masked word of `NUM_SHARES` shares × `NUM_PARTS*PART_WIDTH` bits and emits it as `NUM_PARTS` masked parts, one per handshake, over a valid/ready stream. It sits between wide masked datapath stages (for example, state registers) and narrower masked consumers (for example, S-box or column units). Shares are kept in separate registers and are never combined.

## Interface
- `NUM_SHARES`, default 2: number of Boolean shares; must be ≥ 2.
- `PART_WIDTH`, default 8: bits per output part, per share; must be ≥ 1.
- `NUM_PARTS`, default 4: parts per input word; must be ≥ 1.
- `MSB_FIRST`, default 0: 0 emits part 0 (bits `[PART_WIDTH-1:0]`) first; 1 emits part `NUM_PARTS-1` first.
- Derived `IDX_WIDTH` = max(1, $clog2(NUM_PARTS)).
- `in_clock` input 1: the single clock; all state updates on its rising edge.
- `in_reset` input 1: reset, synchronous and active-high.
- `in_a` input [NUM_SHARES-1:0][NUM_PARTS*PART_WIDTH-1:0]: masked input word.
- `in_a_valid` input 1: `in_a` is valid.
- `out_a_ready` output 1: the block accepts `in_a` this cycle.
- `out_b` output [NUM_SHARES-1:0][PART_WIDTH-1:0]: current masked part.
- `out_b_valid` output 1: `out_b` is valid.
- `in_b_ready` input 1: downstream accepts `out_b`.
- `out_b_index` output [IDX_WIDTH-1:0]: logical part number of `out_b`, in `in_a` bit order.
- `out_b_last` output 1: `out_b` is the final part of the word.

## Operation
- States: IDLE and BUSY.
- Accept occurs when `in_a_valid && out_a_ready`. Emit occurs when `out_b_valid && in_b_ready`.
- `out_a_ready` = IDLE, or (BUSY && `out_b_last` && `in_b_ready`). This is a combinational path from `in_b_ready`, and it allows back-to-back words.
- On accept, each share is loaded into its own shift register, the counter is cleared, and the state becomes BUSY.
- `out_b[i]` is the low part of share register `i` when `MSB_FIRST`=0, and the high part when `MSB_FIRST`=1.
- On emit of a non-last part:
  - each share register shifts by `PART_WIDTH` toward the output end;
  - zeros fill the vacated end, so consumed parts are not retained;
  - the counter increments.
- On emit of the last part: with no simultaneous accept, the state becomes IDLE. With a simultaneous accept, the new word loads and the state stays BUSY.
- `out_b_valid` = BUSY.
- `out_b_last` = BUSY && counter == NUM_PARTS-1.
- `out_b_index` = counter when `MSB_FIRST`=0, and NUM_PARTS-1-counter when `MSB_FIRST`=1.
- When `NUM_PARTS`=1, `out_b_last` is 1 whenever the block is valid, and the counter stays 0.
- Masking rules:
  - no logic may combine bits of different shares;
  - each share path is a mux/shift over its own share only;
  - no randomness is consumed.

## Timing
- Reset (synchronous, `in_reset`=1 at a clock edge):
  - state goes to IDLE, the counter to 0, and all share registers to 0;
  - in the cycle after reset, `out_b_valid`=0, `out_b`=0, `out_b_index`=0, `out_b_last`=0, `out_a_ready`=1.
- Reset in mid-word drops the remaining parts without emitting them. An accept or emit in the same cycle as reset is ignored.
- Latency: part 0 is valid in the cycle after accept. Registered outputs, except `out_a_ready`.
- Throughput: one word per `NUM_PARTS` cycles with `in_b_ready` held at 1.
- Stall: while `out_b_valid` && !`in_b_ready`, `out_b`, `out_b_index` and `out_b_last` hold stable, and `out_a_ready`=0.
- `in_a` is sampled only on accept. Changes to `in_a` while BUSY have no effect.
- In IDLE after a completed word, `out_b`=0 because the share registers have been zero-filled.

## Test plan
Configuration for all scenarios: `NUM_SHARES`=2, `PART_WIDTH`=8, `NUM_PARTS`=4 unless stated.
- Basic LSB-first: load share0=0x44332211, share1=0xDDCCBBAA, `in_b_ready`=1.
  - Expect (0x11,0xAA) idx0, (0x22,0xBB) idx1, (0x33,0xCC) idx2, (0x44,0xDD) idx3 with last=1, on 4 consecutive cycles.
  - Then `out_b_valid`=0 and `out_b`=0.
- `MSB_FIRST`=1, same word: expect (0x44,0xDD) idx3 first, through (0x11,0xAA) idx0 with last=1.
- Backpressure: drop `in_b_ready` for 3 cycles during part 1.
  - Expect (0x22,0xBB) idx1 held stable and `out_a_ready`=0 throughout the stall.
  - Then normal completion.
- Back-to-back: second word 0x08070605/0x0D0C0B0A presented with `in_a_valid`=1 and `in_b_ready`=1 throughout.
  - Expect `out_a_ready`=1 on the cycle of the first word's last part.
  - Expect part (0x05,0x0A) on the very next cycle, giving 8 parts in 8 cycles.
- Reset mid-word: assert `in_reset` after part 1 is emitted.
  - Next cycle: `out_b_valid`=0, `out_b`=0, `out_a_ready`=1.
  - A fresh word then starts at idx0.
- `NUM_PARTS`=1, `PART_WIDTH`=16: word 0xBEEF/0x1234 is emitted in one beat with last=1 and idx0. The block accepts again on that same cycle.
